// File: rtl/ftm_counter_pwm.sv
// Flex Timer counter and PWM core: prescaler, up-counter with CNTIN/MOD reload,
// double-buffered MOD/CnV registers, sticky TOF and edge-aligned PWM outputs.
module ftm_counter_pwm #(
    parameter int unsigned NCH = 8,
    parameter int unsigned CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic           rd_en,
    input  logic [4:0]     reg_sel,
    input  logic [31:0]    data,
    output logic [31:0]    rd_data,
    output logic [NCH-1:0] ch_out,
    output logic [CW-1:0]  cnt,
    output logic           tof_pulse
);

    logic [2:0]     ps_q, ps_d;
    logic [1:0]     clks_q, clks_d;
    logic           tof_q, tof_d;
    logic [6:0]     presc_q, presc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cntin_q, cntin_d;
    logic [CW-1:0]  mod_buf_q, mod_buf_d;
    logic [CW-1:0]  mod_act_q, mod_act_d;
    logic [CW-1:0]  cnv_buf_q [NCH];
    logic [CW-1:0]  cnv_buf_d [NCH];
    logic [CW-1:0]  cnv_act_q [NCH];
    logic [CW-1:0]  cnv_act_d [NCH];
    logic [NCH-1:0] ch_q, ch_d;
    logic [31:0]    rd_q, rd_d;
    logic           tofp_q, tofp_d;

    logic           wr_sc, wr_cnt, wr_mod, wr_cntin;
    logic [NCH-1:0] wr_cnv;
    logic           running, tick, at_end, reload, load_act;
    logic [6:0]     presc_lim;

    // Register-write decode, prescaler tick and reload detection
    always_comb begin
        wr_sc    = wr_en && (reg_sel == 5'd0);
        wr_cnt   = wr_en && (reg_sel == 5'd1);
        wr_mod   = wr_en && (reg_sel == 5'd2);
        wr_cntin = wr_en && (reg_sel == 5'd3);
        for (int n = 0; n < NCH; n++) begin
            wr_cnv[n] = wr_en && (reg_sel == 5'(4 + n));
        end
        running   = (clks_q != 2'b00);
        // 2^PS-1 in 7 bits; PS=7 wraps 1<<7 to 0 and yields 127 as required
        presc_lim = (7'd1 << ps_q) - 7'd1;
        tick      = running && (presc_q == presc_lim);
        at_end    = (cnt_q == mod_act_q) || (cnt_q == '1);
        // A CNT write overrides the tick, so that cycle never counts as a reload
        reload    = tick && at_end && !wr_cnt;
        load_act  = reload || wr_cnt;
    end

    // Next-state for control, counter and buffered compare registers
    always_comb begin
        ps_d      = ps_q;
        clks_d    = clks_q;
        tof_d     = tof_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        cntin_d   = cntin_q;
        mod_buf_d = mod_buf_q;
        mod_act_d = mod_act_q;
        for (int n = 0; n < NCH; n++) begin
            cnv_buf_d[n] = cnv_buf_q[n];
            cnv_act_d[n] = cnv_act_q[n];
        end

        if (running) begin
            presc_d = tick ? 7'd0 : presc_q + 7'd1;
        end

        if (wr_sc) begin
            ps_d   = data[2:0];
            clks_d = data[4:3];
            if (!data[7]) begin
                tof_d = 1'b0;
            end
            if (data[2:0] != ps_q) begin
                presc_d = 7'd0;
            end
        end
        // Hardware set wins over a simultaneous software clear
        if (reload) begin
            tof_d = 1'b1;
        end

        if (wr_cnt) begin
            cnt_d = cntin_q;
        end else if (tick) begin
            cnt_d = at_end ? cntin_q : cnt_q + CW'(1);
        end

        // Copy the pre-edge buffers; a same-cycle write lands in the buffer only
        if (load_act) begin
            mod_act_d = mod_buf_q;
            for (int n = 0; n < NCH; n++) begin
                cnv_act_d[n] = cnv_buf_q[n];
            end
        end

        if (wr_mod) begin
            mod_buf_d = data[CW-1:0];
            if (!running) begin
                mod_act_d = data[CW-1:0];
            end
        end
        for (int n = 0; n < NCH; n++) begin
            if (wr_cnv[n]) begin
                cnv_buf_d[n] = data[CW-1:0];
                if (!running) begin
                    cnv_act_d[n] = data[CW-1:0];
                end
            end
        end

        if (wr_cntin) begin
            cntin_d = data[CW-1:0];
        end
    end

    // PWM compare, overflow pulse and read mux (all from pre-edge values)
    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            ch_d[n] = (cnt_q < cnv_act_q[n]);
        end
        tofp_d = reload;
        rd_d   = rd_q;
        if (rd_en) begin
            rd_d = 32'd0;
            case (reg_sel)
                5'd0:    rd_d = {24'd0, tof_q, 2'b00, clks_q, ps_q};
                5'd1:    rd_d = 32'(cnt_q);
                5'd2:    rd_d = 32'(mod_buf_q);
                5'd3:    rd_d = 32'(cntin_q);
                default: rd_d = 32'd0;
            endcase
            for (int n = 0; n < NCH; n++) begin
                if (reg_sel == 5'(4 + n)) begin
                    rd_d = 32'(cnv_buf_q[n]);
                end
            end
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q      <= '0;
            clks_q    <= '0;
            tof_q     <= 1'b0;
            presc_q   <= '0;
            cnt_q     <= '0;
            cntin_q   <= '0;
            mod_buf_q <= '0;
            mod_act_q <= '0;
            for (int n = 0; n < NCH; n++) begin
                cnv_buf_q[n] <= '0;
                cnv_act_q[n] <= '0;
            end
            ch_q      <= '0;
            rd_q      <= '0;
            tofp_q    <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            clks_q    <= clks_d;
            tof_q     <= tof_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            cntin_q   <= cntin_d;
            mod_buf_q <= mod_buf_d;
            mod_act_q <= mod_act_d;
            for (int n = 0; n < NCH; n++) begin
                cnv_buf_q[n] <= cnv_buf_d[n];
                cnv_act_q[n] <= cnv_act_d[n];
            end
            ch_q      <= ch_d;
            rd_q      <= rd_d;
            tofp_q    <= tofp_d;
        end
    end

    assign rd_data   = rd_q;
    assign ch_out    = ch_q;
    assign cnt       = cnt_q;
    assign tof_pulse = tofp_q;

endmodule

// File: tb/tb_ftm_counter_pwm.sv
// Self-checking bench for ftm_counter_pwm: cycle model compared every cycle,
// directed scenarios with literal expectations, then randomized register traffic.
module tb_ftm_counter_pwm;

    localparam int NCH  = 8;
    localparam int CW   = 16;
    localparam int ONES = (1 << CW) - 1;

    logic           clk;
    logic           rst_n;
    logic           wr_en;
    logic           rd_en;
    logic [4:0]     reg_sel;
    logic [31:0]    data;
    logic [31:0]    rd_data;
    logic [NCH-1:0] ch_out;
    logic [CW-1:0]  cnt;
    logic           tof_pulse;

    int checks;
    int failures;

    ftm_counter_pwm #(.NCH(NCH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .reg_sel   (reg_sel),
        .data      (data),
        .rd_data   (rd_data),
        .ch_out    (ch_out),
        .cnt       (cnt),
        .tof_pulse (tof_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ps, m_clks, m_pre, m_cnt, m_cntin, m_mod_buf, m_mod_act;
    int          m_cnv_buf [NCH];
    int          m_cnv_act [NCH];
    bit          m_tof, m_tofp;
    bit [NCH-1:0] m_ch;
    logic [31:0] m_rd;
    bit          t_run, t_tick, t_reload, t_copy;
    int          t_sel, t_d;

    function automatic logic [31:0] model_read(input int sel);
        if (sel == 0) return 32'((int'(m_tof) << 7) | (m_clks << 3) | m_ps);
        if (sel == 1) return 32'(m_cnt);
        if (sel == 2) return 32'(m_mod_buf);
        if (sel == 3) return 32'(m_cntin);
        if (sel >= 4 && sel < 4 + NCH) return 32'(m_cnv_buf[sel-4]);
        return 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ps = 0; m_clks = 0; m_pre = 0; m_cnt = 0; m_cntin = 0;
            m_mod_buf = 0; m_mod_act = 0; m_tof = 0; m_tofp = 0; m_ch = '0; m_rd = '0;
            for (int n = 0; n < NCH; n++) begin
                m_cnv_buf[n] = 0;
                m_cnv_act[n] = 0;
            end
        end else begin
            t_sel  = int'(reg_sel);
            t_d    = int'(data);
            t_run  = (m_clks != 0);
            t_tick = t_run && (m_pre == (1 << m_ps) - 1);
            // Everything observable is computed from the state before this edge
            if (rd_en) m_rd = model_read(t_sel);
            for (int n = 0; n < NCH; n++) m_ch[n] = (m_cnt < m_cnv_act[n]);
            if (t_run) m_pre = t_tick ? 0 : m_pre + 1;
            t_reload = 0;
            t_copy   = 0;
            if (wr_en && t_sel == 1) begin
                m_cnt  = m_cntin;
                t_copy = 1;
            end else if (t_tick) begin
                if (m_cnt == m_mod_act || m_cnt == ONES) begin
                    m_cnt    = m_cntin;
                    t_reload = 1;
                    t_copy   = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (t_copy) begin
                m_mod_act = m_mod_buf;
                for (int n = 0; n < NCH; n++) m_cnv_act[n] = m_cnv_buf[n];
            end
            if (wr_en) begin
                if (t_sel == 0) begin
                    if ((t_d & 7) != m_ps) m_pre = 0;
                    m_ps   = t_d & 7;
                    m_clks = (t_d >> 3) & 3;
                    if (((t_d >> 7) & 1) == 0) m_tof = 0;
                end else if (t_sel == 2) begin
                    m_mod_buf = t_d & ONES;
                    if (!t_run) m_mod_act = m_mod_buf;
                end else if (t_sel == 3) begin
                    m_cntin = t_d & ONES;
                end else if (t_sel >= 4 && t_sel < 4 + NCH) begin
                    m_cnv_buf[t_sel-4] = t_d & ONES;
                    if (!t_run) m_cnv_act[t_sel-4] = m_cnv_buf[t_sel-4];
                end
            end
            if (t_reload) m_tof = 1;
            m_tofp = t_reload;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("cnt", 32'(cnt), 32'(m_cnt));
        chk("ch_out", 32'(ch_out), 32'(m_ch));
        chk("tof_pulse", 32'(tof_pulse), 32'(m_tofp));
        chk("rd_data", rd_data, m_rd);
    end

    // ---------------- stimulus helpers ----------------
    task automatic op(input bit w, input bit r, input int sel, input logic [31:0] d);
        wr_en   = w;
        rd_en   = r;
        reg_sel = 5'(sel);
        data    = d;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (tof_pulse) ok = 1;
        end
    endtask

    task automatic measure_period(output int p);
        bit ok;
        p = -1;
        wait_pulse(ok);
        if (ok) begin
            for (int i = 1; i <= 300 && p < 0; i++) begin
                @(negedge clk);
                if (tof_pulse) p = i;
            end
        end
    endtask

    int  per;
    bit  ok;
    int  h0, h1, h2;
    int  r, sel;
    logic [31:0] d;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; reg_sel = '0; data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_ch", 32'(ch_out), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_tofp", 32'(tof_pulse), 32'd0);

        // Free run: MOD=9, PS=0
        op(1, 0, 3, 32'd0);
        op(1, 0, 2, 32'd9);
        op(1, 0, 0, 32'h08);
        measure_period(per);
        chk("free_period", 32'(per), 32'd10);
        chk("free_reload_cnt", 32'(cnt), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("free_step", 32'(cnt), 32'(i));
        end
        @(negedge clk);
        chk("free_wrap", 32'(cnt), 32'd0);
        chk("free_wrap_pulse", 32'(tof_pulse), 32'd1);
        op(0, 1, 0, 32'd0);
        chk("free_sc_tof", rd_data, 32'h88);

        // Duty cycle, buffered until the next reload
        op(1, 0, 4, 32'd3);
        op(1, 0, 5, 32'd0);
        op(1, 0, 6, 32'd12);
        wait_pulse(ok);
        chk("duty_pulse_seen", 32'(ok), 32'd1);
        h0 = 0; h1 = 0; h2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            h0 += int'(ch_out[0]);
            h1 += int'(ch_out[1]);
            h2 += int'(ch_out[2]);
        end
        chk("duty_ch0", 32'(h0), 32'd6);
        chk("duty_ch1", 32'(h1), 32'd0);
        chk("duty_ch2", 32'(h2), 32'd20);

        // Buffered update mid-period
        wait_pulse(ok);
        repeat (3) @(negedge clk);
        op(1, 0, 2, 32'd4);
        op(1, 0, 4, 32'd2);
        op(0, 1, 2, 32'd0);
        chk("buf_mod_read", rd_data, 32'd4);
        measure_period(per);
        chk("buf_period", 32'(per), 32'd5);

        // Prescaler PS=2, MOD=3 -> 16-clock period
        op(1, 0, 0, 32'h0A);
        op(1, 0, 2, 32'd3);
        measure_period(per);
        chk("presc_period", 32'(per), 32'd16);

        // All-ones boundary: CNTIN above MOD runs to 0xFFFF then reloads
        op(1, 0, 0, 32'h08);
        op(1, 0, 3, 32'hFFF0);
        op(1, 0, 1, 32'd0);
        chk("ones_cnt_load", 32'(cnt), 32'hFFF0);
        measure_period(per);
        chk("ones_period", 32'(per), 32'd16);
        chk("ones_reload_cnt", 32'(cnt), 32'hFFF0);

        // CNT write colliding with a reload tick
        op(1, 0, 3, 32'd0);
        op(1, 0, 2, 32'd9);
        op(1, 0, 1, 32'd0);
        op(1, 0, 0, 32'h08);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (cnt == 16'd9) ok = 1;
            else @(negedge clk);
        end
        chk("coll_reach_mod", 32'(ok), 32'd1);
        op(1, 0, 1, 32'h1234);
        chk("coll_cnt", 32'(cnt), 32'd0);
        chk("coll_tofp", 32'(tof_pulse), 32'd0);
        op(0, 1, 0, 32'd0);
        chk("coll_sc", rd_data, 32'h08);

        // Randomized register traffic, checked by the model every cycle
        for (int k = 0; k < 2500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                op(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
            end else begin
                sel = $urandom_range(0, 15);
                case (sel)
                    0: d = 32'(($urandom_range(0, 1) << 7) |
                                ($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 3)) << 3 |
                                $urandom_range(0, 2));
                    2: d = 32'($urandom_range(4, 20));
                    3: d = 32'($urandom_range(0, 3));
                    4, 5, 6, 7, 8, 9, 10, 11: d = 32'($urandom_range(0, 24));
                    default: d = $urandom;
                endcase
                op(1, 1'($urandom_range(0, 1)), sel, d);
            end
        end

        // Asynchronous reset between edges
        op(1, 0, 0, 32'h08);
        op(1, 0, 3, 32'd0);
        op(1, 0, 2, 32'd9);
        op(1, 0, 4, 32'd12);
        op(1, 0, 1, 32'd0);
        op(0, 1, 2, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_ch", 32'(ch_out), 32'd0);
        chk("arst_tofp", 32'(tof_pulse), 32'd0);
        chk("arst_rd", rd_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_stopped", 32'(cnt), 32'd0);
        op(0, 1, 0, 32'd0);
        chk("arst_sc", rd_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ftm_counter_pwm.md
# ftm_counter_pwm

Counter and PWM-generation core of the Flex Timer. It consumes the register write/read bus driven on the FTM interface (`wr_en`, `rd_en`, register select, `data`). It produces the eight edge-aligned PWM channel outputs CH0..CH7 that the monitor side of the interface samples. It holds the counter, the prescaler, buffered MOD/CnV registers and the timer-overflow flag.

## Interface
- `NCH`, 8, number of PWM channels
- `CW`, 16, counter and compare width
- `clk`  in  1  single timer clock
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  register write strobe, one write per cycle
- `rd_en`  in  1  register read strobe
- `reg_sel`  in  5  register code: 0=SC, 1=CNT, 2=MOD, 3=CNTIN, 4..11=C0V..C7V; all other codes are unmapped
- `data`  in  32  write data; only bits [CW-1:0] are used, except for SC
- `rd_data`  out  32  read data, zero-extended
- `ch_out`  out  NCH  PWM outputs; bit n drives CHn
- `cnt`  out  CW  current counter value
- `tof_pulse`  out  1  one-cycle pulse on each counter reload

## Operation
- **SC register**
  - bits [2:0] PS: prescale divide 2^PS.
  - bits [4:3] CLKS: 00 = stopped; any other value = run.
  - bit 7 TOF: sticky.
- **Writing SC**
  - Updates PS and CLKS.
  - Clears TOF only if data[7]=0. Writing 1 leaves TOF unchanged.
  - Any change of PS clears the prescaler counter.
- **Prescaler**
  - Free-running counter, enabled only while CLKS≠00.
  - Emits `tick` when it equals 2^PS−1, then wraps to 0.
  - With PS=0, `tick` is asserted on every cycle.
- **Counter**
  - Advances only on `tick`.
  - If cnt==MOD_act or cnt==all-ones, the next value is CNTIN. This is the reload.
  - Otherwise cnt+1.
  - If CNTIN>MOD, the counter runs to all-ones, then reloads.
- **Reload actions**, performed in the same clock edge as the reload:
  - Set TOF.
  - Pulse `tof_pulse`.
  - Copy MOD_buf→MOD_act and CnV_buf→CnV_act for all channels.
- **Writing MOD/CnV** writes only the buffer.
  - While CLKS=00, the buffer is also copied to the active register on the same edge.
- **Writing CNTIN** takes effect immediately, with no buffering.
- **Writing CNT**, any data value:
  - Sets cnt to CNTIN.
  - Does not set TOF.
  - Loads the buffered values into the active registers.
  - Has priority over a tick-driven advance or reload in the same cycle. That cycle produces no TOF and no `tof_pulse`.
- **PWM output**
  - ch_out[n] is a register: ch_out[n] ← (cnt < CnV_act[n]), evaluated on the pre-edge values every cycle.
  - CnV=0 gives a constant low output (0 %).
  - CnV>MOD gives a constant high output (100 %).
  - With CLKS=00, the outputs hold at the value implied by the frozen cnt.
- **Reads**
  - Reads of MOD/CnV return the buffer contents.
  - Reads of SC return {24'b0, TOF, 2'b0, CLKS, PS}.
  - Unmapped codes read as 0. Writes to unmapped codes are ignored.
- **Simultaneous wr_en and rd_en**
  - The write is performed.
  - The read returns the pre-write value.

## Timing
- **Reset values**
  - All registers are 0: SC, CNTIN, MOD_buf/act, CnV_buf/act, cnt, prescaler, TOF.
  - Outputs: `ch_out`=0, `rd_data`=0, `tof_pulse`=0.
- **Write latency**: `wr_en` sampled at edge k; the register holds the new value after edge k.
- **Read latency**: `rd_data` is valid one cycle after `rd_en`. It holds its value until the next `rd_en`.
- **Counter**: with PS=0 it advances every clock.
- **Reload cycle**:
  - `cnt` shows CNTIN after edge k.
  - `tof_pulse` is high for the single cycle following edge k.
  - TOF reads 1 for a read issued at or after edge k+1.
- **PWM lag**: ch_out lags cnt by exactly one cycle.
  - Example: cnt=CnV appears after edge k; ch_out[n] falls after edge k+1.
- **Reset during operation**: asserting rst_n low clears every register immediately, independent of `clk`.

## Test plan
- **Free run**: reset, write CNTIN=0, MOD=9, CLKS=01, PS=0 → cnt steps 0..9 and then 0. Period is 10 clocks. `tof_pulse` occurs once per period. SC read shows bit 7=1.
- **Duty cycle**: MOD=9, C0V=3, C1V=0, C2V=12 → CH0 high for 3 of every 10 clocks, one-cycle lag after cnt. CH1 stays low. CH2 stays high.
- **Buffered update**: while running, write MOD=4 and C0V=2 mid-period → the old period completes. The new 5-clock period and 2-high duty start exactly at the next reload. MOD reads 4 immediately.
- **Prescaler**: PS=2, MOD=3 → cnt advances every 4th clock. Period is 16 clocks. Changing PS restarts the prescale count from 0.
- **CNT write collision**: write CNT on the same cycle cnt==MOD with a tick → cnt=CNTIN, no `tof_pulse`. A subsequent SC read shows TOF unchanged.
- **Async reset**: drop rst_n mid-period between clock edges → all outputs are 0 before the next edge. The counter restarts from 0, stopped, after release.
